// File: rtl/proc_alu_n.sv
// Parametrised bus processor: one register-transfer or ALU instruction per w request,
// sequenced through steps T0..T3 over a multiplexed internal bus, with carry and zero flags.
module proc_alu_n #(
    parameter int N    = 8,
    parameter int REGS = 4
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic [N-1:0]            Data,
    input  logic                    w,
    input  logic [2:0]              F,
    input  logic [$clog2(REGS)-1:0] Rx,
    input  logic [$clog2(REGS)-1:0] Ry,
    output logic                    Done,
    output logic [N-1:0]            BusWires,
    output logic                    Carry,
    output logic                    Zero
);

    localparam int RW = $clog2(REGS);

    typedef enum logic [1:0] {T0, T1, T2, T3} state_t;
    typedef enum logic [2:0] {
        OP_MV  = 3'b000,
        OP_MVI = 3'b001,
        OP_ADD = 3'b010,
        OP_SUB = 3'b011,
        OP_AND = 3'b100,
        OP_OR  = 3'b101,
        OP_XOR = 3'b110,
        OP_CMP = 3'b111
    } opcode_t;

    state_t          state, nextState;
    logic [2+2*RW:0] ir;
    opcode_t         irF;
    logic [RW-1:0]   irRx, irRy;
    logic [N-1:0]    regs [REGS];
    logic [N-1:0]    a, g, aluResult;
    logic            aluCarry;
    logic            aLoad, gLoad, rLoad;

    assign irF  = opcode_t'(ir[2+2*RW -: 3]);
    assign irRx = ir[2*RW-1 -: RW];
    assign irRy = ir[RW-1:0];

    // Step sequencing and bus source selection; the bus idles at zero in T0.
    always_comb begin
        nextState = state;
        Done      = 1'b0;
        BusWires  = '0;
        aLoad     = 1'b0;
        gLoad     = 1'b0;
        rLoad     = 1'b0;
        case (state)
            T0: if (w) nextState = T1;
            T1: begin
                case (irF)
                    OP_MV: begin
                        BusWires  = regs[irRy];
                        rLoad     = 1'b1;
                        Done      = 1'b1;
                        nextState = T0;
                    end
                    OP_MVI: begin
                        BusWires  = Data;
                        rLoad     = 1'b1;
                        Done      = 1'b1;
                        nextState = T0;
                    end
                    default: begin
                        BusWires  = regs[irRx];
                        aLoad     = 1'b1;
                        nextState = T2;
                    end
                endcase
            end
            T2: begin
                BusWires = regs[irRy];
                gLoad    = 1'b1;
                if (irF == OP_CMP) begin
                    Done      = 1'b1;
                    nextState = T0;
                end else begin
                    nextState = T3;
                end
            end
            T3: begin
                BusWires  = g;
                rLoad     = 1'b1;
                Done      = 1'b1;
                nextState = T0;
            end
            default: nextState = T0;
        endcase
    end

    // Carry doubles as borrow for sub/cmp: the extra top bit of the widened difference.
    always_comb begin
        aluResult = '0;
        aluCarry  = 1'b0;
        case (irF)
            OP_ADD:         {aluCarry, aluResult} = {1'b0, a} + {1'b0, BusWires};
            OP_SUB, OP_CMP: {aluCarry, aluResult} = {1'b0, a} - {1'b0, BusWires};
            OP_AND:         aluResult = a & BusWires;
            OP_OR:          aluResult = a | BusWires;
            OP_XOR:         aluResult = a ^ BusWires;
            default:        aluResult = '0;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= T0;
            ir    <= '0;
            a     <= '0;
            g     <= '0;
            Carry <= 1'b0;
            Zero  <= 1'b0;
            for (int i = 0; i < REGS; i++) regs[i] <= '0;
        end else begin
            state <= nextState;
            if (state == T0 && w) ir <= {F, Rx, Ry};
            if (aLoad) a <= BusWires;
            if (gLoad) begin
                g     <= aluResult;
                Carry <= aluCarry;
                Zero  <= (aluResult == '0);
            end
            if (rLoad) regs[irRx] <= BusWires;
        end
    end

endmodule

// File: tb/tb_proc_alu_n.sv
// Directed bench for proc_alu_n: an 8-bit/4-register and a 16-bit/8-register instance,
// registers observed through the bus by issuing mv Rk,Rk.
module tb_proc_alu_n;

    localparam logic [2:0] MV = 3'd0, MVI = 3'd1, ADD = 3'd2, SUB = 3'd3;
    localparam logic [2:0] AND = 3'd4, OR = 3'd5, XOR = 3'd6, CMP = 3'd7;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  data8 = '0;
    logic        w8 = 1'b0;
    logic [2:0]  f8 = '0;
    logic [1:0]  rx8 = '0, ry8 = '0;
    logic        done8, carry8, zero8;
    logic [7:0]  bus8;
    logic [15:0] data16 = '0;
    logic        w16 = 1'b0;
    logic [2:0]  f16 = '0;
    logic [2:0]  rx16 = '0, ry16 = '0;
    logic        done16, carry16, zero16;
    logic [15:0] bus16;

    int assertCount = 0;
    int failCount   = 0;

    always #5 clock = ~clock;

    proc_alu_n #(.N(8), .REGS(4)) dut8 (
        .Clock(clock), .Reset(reset), .Data(data8), .w(w8), .F(f8), .Rx(rx8), .Ry(ry8),
        .Done(done8), .BusWires(bus8), .Carry(carry8), .Zero(zero8)
    );

    proc_alu_n #(.N(16), .REGS(8)) dut16 (
        .Clock(clock), .Reset(reset), .Data(data16), .w(w16), .F(f16), .Rx(rx16), .Ry(ry16),
        .Done(done16), .BusWires(bus16), .Carry(carry16), .Zero(zero16)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Issue one instruction and follow it to Done (bounded), recording bus per step.
    task automatic applyStimulus8(input logic [2:0] f, input logic [1:0] x, input logic [1:0] y,
                                  input logic [7:0] d, output int doneCycle,
                                  output logic [7:0] b1, output logic [7:0] b2, output logic [7:0] b3);
        logic [7:0] bv [1:5];
        for (int i = 1; i <= 5; i++) bv[i] = 'x;
        f8 = f; rx8 = x; ry8 = y; data8 = d; w8 = 1'b1;
        tick();
        w8 = 1'b0;
        doneCycle = 0;
        for (int c = 1; c <= 5; c++) begin
            bv[c] = bus8;
            if (done8) begin
                doneCycle = c;
                break;
            end
            tick();
        end
        b1 = bv[1]; b2 = bv[2]; b3 = bv[3];
        tick();
    endtask

    task automatic applyStimulus16(input logic [2:0] f, input logic [2:0] x, input logic [2:0] y,
                                   input logic [15:0] d, output int doneCycle, output logic [15:0] b1);
        logic [15:0] bv [1:5];
        for (int i = 1; i <= 5; i++) bv[i] = 'x;
        f16 = f; rx16 = x; ry16 = y; data16 = d; w16 = 1'b1;
        tick();
        w16 = 1'b0;
        doneCycle = 0;
        for (int c = 1; c <= 5; c++) begin
            bv[c] = bus16;
            if (done16) begin
                doneCycle = c;
                break;
            end
            tick();
        end
        b1 = bv[1];
        tick();
    endtask

    task automatic readReg8(input logic [1:0] r, output logic [7:0] v);
        int dc;
        logic [7:0] t2, t3;
        applyStimulus8(MV, r, r, data8, dc, v, t2, t3);
    endtask

    task automatic readReg16(input logic [2:0] r, output logic [15:0] v);
        int dc;
        applyStimulus16(MV, r, r, data16, dc, v);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        assertCount++; if (done8 !== 1'b0) begin failCount++; $display("[TB] FAIL reset_done: got %b expected 0", done8); end
        assertCount++; if (bus8 !== 8'h00) begin failCount++; $display("[TB] FAIL reset_bus: got %h expected 00", bus8); end
        assertCount++; if ({carry8, zero8} !== 2'b00) begin failCount++; $display("[TB] FAIL reset_flags: got %b expected 00", {carry8, zero8}); end
        assertCount++; if ({done16, carry16, zero16, bus16} !== 19'd0) begin failCount++; $display("[TB] FAIL reset_wide: got %h expected 0", {done16, carry16, zero16, bus16}); end
    endtask

    task automatic test_mvi();
        int dc;
        logic [7:0] b1, b2, b3, v;
        applyStimulus8(MVI, 2'd0, 2'd0, 8'h05, dc, b1, b2, b3);
        assertCount++; if (dc !== 1) begin failCount++; $display("[TB] FAIL mvi_latency: got %0d expected 1", dc); end
        assertCount++; if (b1 !== 8'h05) begin failCount++; $display("[TB] FAIL mvi_bus: got %h expected 05", b1); end
        assertCount++; if ({carry8, zero8} !== 2'b00) begin failCount++; $display("[TB] FAIL mvi_flags: got %b expected 00", {carry8, zero8}); end
        readReg8(2'd0, v);
        assertCount++; if (v !== 8'h05) begin failCount++; $display("[TB] FAIL mvi_r0: got %h expected 05", v); end
    endtask

    task automatic test_add();
        int dc;
        logic [7:0] b1, b2, b3, v;
        applyStimulus8(MVI, 2'd1, 2'd0, 8'hFF, dc, b1, b2, b3);
        applyStimulus8(MVI, 2'd2, 2'd0, 8'h01, dc, b1, b2, b3);
        applyStimulus8(ADD, 2'd1, 2'd2, 8'h00, dc, b1, b2, b3);
        assertCount++; if (dc !== 3) begin failCount++; $display("[TB] FAIL add_latency: got %0d expected 3", dc); end
        assertCount++; if ({b1, b2, b3} !== 24'hFF0100) begin failCount++; $display("[TB] FAIL add_bus: got %h expected ff0100", {b1, b2, b3}); end
        assertCount++; if ({carry8, zero8} !== 2'b11) begin failCount++; $display("[TB] FAIL add_flags: got %b expected 11", {carry8, zero8}); end
        readReg8(2'd1, v);
        assertCount++; if (v !== 8'h00) begin failCount++; $display("[TB] FAIL add_r1: got %h expected 00", v); end
    endtask

    task automatic test_sub_cmp();
        int dc;
        logic [7:0] b1, b2, b3, v;
        applyStimulus8(MVI, 2'd1, 2'd0, 8'h03, dc, b1, b2, b3);
        assertCount++; if ({carry8, zero8} !== 2'b11) begin failCount++; $display("[TB] FAIL mvi_keeps_flags: got %b expected 11", {carry8, zero8}); end
        applyStimulus8(MVI, 2'd2, 2'd0, 8'h05, dc, b1, b2, b3);
        applyStimulus8(SUB, 2'd1, 2'd2, 8'h00, dc, b1, b2, b3);
        assertCount++; if ({carry8, zero8} !== 2'b10) begin failCount++; $display("[TB] FAIL sub_flags: got %b expected 10", {carry8, zero8}); end
        readReg8(2'd1, v);
        assertCount++; if (v !== 8'hFE) begin failCount++; $display("[TB] FAIL sub_r1: got %h expected fe", v); end
        applyStimulus8(CMP, 2'd2, 2'd2, 8'h00, dc, b1, b2, b3);
        assertCount++; if (dc !== 2) begin failCount++; $display("[TB] FAIL cmp_latency: got %0d expected 2", dc); end
        assertCount++; if ({carry8, zero8} !== 2'b01) begin failCount++; $display("[TB] FAIL cmp_flags: got %b expected 01", {carry8, zero8}); end
        readReg8(2'd2, v);
        assertCount++; if (v !== 8'h05) begin failCount++; $display("[TB] FAIL cmp_r2: got %h expected 05", v); end
    endtask

    task automatic test_logic();
        int dc;
        logic [7:0] b1, b2, b3, v;
        applyStimulus8(MVI, 2'd3, 2'd0, 8'hA5, dc, b1, b2, b3);
        f8 = XOR; rx8 = 2'd3; ry8 = 2'd3; w8 = 1'b1;
        tick();
        w8 = 1'b0;
        tick();
        f8 = MVI; rx8 = 2'd0; data8 = 8'h77; w8 = 1'b1;
        assertCount++; if (done8 !== 1'b0) begin failCount++; $display("[TB] FAIL xor_t2_done: got %b expected 0", done8); end
        tick();
        w8 = 1'b0;
        assertCount++; if ({done8, bus8} !== 9'h100) begin failCount++; $display("[TB] FAIL xor_t3: got %h expected 100", {done8, bus8}); end
        tick();
        assertCount++; if ({done8, bus8} !== 9'h000) begin failCount++; $display("[TB] FAIL xor_t0: got %h expected 000", {done8, bus8}); end
        tick();
        assertCount++; if ({done8, bus8} !== 9'h000) begin failCount++; $display("[TB] FAIL w_not_queued: got %h expected 000", {done8, bus8}); end
        assertCount++; if ({carry8, zero8} !== 2'b01) begin failCount++; $display("[TB] FAIL xor_flags: got %b expected 01", {carry8, zero8}); end
        readReg8(2'd3, v);
        assertCount++; if (v !== 8'h00) begin failCount++; $display("[TB] FAIL xor_r3: got %h expected 00", v); end
        readReg8(2'd0, v);
        assertCount++; if (v !== 8'h05) begin failCount++; $display("[TB] FAIL r0_untouched: got %h expected 05", v); end

        applyStimulus8(MVI, 2'd0, 2'd0, 8'hF0, dc, b1, b2, b3);
        applyStimulus8(MVI, 2'd1, 2'd0, 8'h3C, dc, b1, b2, b3);
        applyStimulus8(AND, 2'd0, 2'd1, 8'h00, dc, b1, b2, b3);
        assertCount++; if ({b3, carry8, zero8} !== {8'h30, 2'b00}) begin failCount++; $display("[TB] FAIL and_result: got %h expected %h", {b3, carry8, zero8}, {8'h30, 2'b00}); end
        applyStimulus8(MVI, 2'd2, 2'd0, 8'h0F, dc, b1, b2, b3);
        applyStimulus8(CMP, 2'd2, 2'd1, 8'h00, dc, b1, b2, b3);
        assertCount++; if ({carry8, zero8} !== 2'b10) begin failCount++; $display("[TB] FAIL cmp_borrow: got %b expected 10", {carry8, zero8}); end
        applyStimulus8(OR, 2'd2, 2'd1, 8'h00, dc, b1, b2, b3);
        assertCount++; if ({b3, carry8, zero8} !== {8'h3F, 2'b00}) begin failCount++; $display("[TB] FAIL or_result: got %h expected %h", {b3, carry8, zero8}, {8'h3F, 2'b00}); end
        applyStimulus8(ADD, 2'd2, 2'd2, 8'h00, dc, b1, b2, b3);
        readReg8(2'd2, v);
        assertCount++; if ({v, carry8, zero8} !== {8'h7E, 2'b00}) begin failCount++; $display("[TB] FAIL add_double: got %h expected %h", {v, carry8, zero8}, {8'h7E, 2'b00}); end
    endtask

    task automatic test_reset_mid();
        int dc;
        logic [7:0] b1, b2, b3, v;
        applyStimulus8(MVI, 2'd1, 2'd0, 8'h11, dc, b1, b2, b3);
        applyStimulus8(MVI, 2'd2, 2'd0, 8'h22, dc, b1, b2, b3);
        applyStimulus8(CMP, 2'd1, 2'd2, 8'h00, dc, b1, b2, b3);
        f8 = ADD; rx8 = 2'd1; ry8 = 2'd2; w8 = 1'b1;
        tick();
        w8 = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        assertCount++; if ({done8, bus8, carry8, zero8} !== 11'd0) begin failCount++; $display("[TB] FAIL midreset_outputs: got %h expected 000", {done8, bus8, carry8, zero8}); end
        tick();
        assertCount++; if ({done8, bus8} !== 9'h000) begin failCount++; $display("[TB] FAIL midreset_idle: got %h expected 000", {done8, bus8}); end
        readReg8(2'd1, v);
        assertCount++; if (v !== 8'h00) begin failCount++; $display("[TB] FAIL midreset_r1: got %h expected 00", v); end
        readReg8(2'd0, v);
        assertCount++; if (v !== 8'h00) begin failCount++; $display("[TB] FAIL midreset_r0: got %h expected 00", v); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] v;
        f8 = MVI; rx8 = 2'd3; ry8 = 2'd0; data8 = 8'h12; w8 = 1'b1;
        tick();
        assertCount++; if ({done8, bus8} !== 9'h112) begin failCount++; $display("[TB] FAIL b2b_first: got %h expected 112", {done8, bus8}); end
        tick();
        assertCount++; if ({done8, bus8} !== 9'h000) begin failCount++; $display("[TB] FAIL b2b_gap: got %h expected 000", {done8, bus8}); end
        tick();
        w8 = 1'b0;
        assertCount++; if ({done8, bus8} !== 9'h112) begin failCount++; $display("[TB] FAIL b2b_second: got %h expected 112", {done8, bus8}); end
        tick();
        readReg8(2'd3, v);
        assertCount++; if (v !== 8'h12) begin failCount++; $display("[TB] FAIL b2b_r3: got %h expected 12", v); end
    endtask

    task automatic test_wide();
        int dc;
        logic [15:0] b1, v;
        applyStimulus16(MVI, 3'd0, 3'd0, 16'h1234, dc, b1);
        applyStimulus16(MVI, 3'd7, 3'd0, 16'h8000, dc, b1);
        applyStimulus16(MVI, 3'd6, 3'd0, 16'h8000, dc, b1);
        applyStimulus16(ADD, 3'd7, 3'd6, 16'h0000, dc, b1);
        assertCount++; if (dc !== 3) begin failCount++; $display("[TB] FAIL wide_add_latency: got %0d expected 3", dc); end
        assertCount++; if ({carry16, zero16} !== 2'b11) begin failCount++; $display("[TB] FAIL wide_add_flags: got %b expected 11", {carry16, zero16}); end
        readReg16(3'd7, v);
        assertCount++; if (v !== 16'h0000) begin failCount++; $display("[TB] FAIL wide_r7: got %h expected 0000", v); end
        readReg16(3'd6, v);
        assertCount++; if (v !== 16'h8000) begin failCount++; $display("[TB] FAIL wide_r6: got %h expected 8000", v); end
        applyStimulus16(MV, 3'd0, 3'd7, 16'h0000, dc, b1);
        assertCount++; if (dc !== 1) begin failCount++; $display("[TB] FAIL wide_mv_latency: got %0d expected 1", dc); end
        readReg16(3'd0, v);
        assertCount++; if (v !== 16'h0000) begin failCount++; $display("[TB] FAIL wide_r0: got %h expected 0000", v); end
    endtask

    initial begin
        test_reset();
        test_mvi();
        test_add();
        test_sub_cmp();
        test_logic();
        test_reset_mid();
        test_back_to_back();
        test_wide();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/proc_alu_n.md
# proc_alu_n

Parametrised successor to the team's 4-register, 8-bit bus processor. It executes one register-transfer or ALU instruction per `w` request over a shared internal bus, and it adds the following:
- configurable data width and register count;
- a 3-bit opcode with logic and compare operations;
- carry and zero flags.

It sits as the datapath/control core driven by an instruction-issuing test harness or sequencer, which presents `{F, Rx, Ry}` with `w` and waits for `Done`.

## Interface
- `N`, 8: data width of registers, bus, `Data`, ALU (N ≥ 2).
- `REGS`, 4: number of general registers R0..R(REGS-1); power of two, ≥ 2.
- `RW`, $clog2(REGS): register index width (derived, not overridden).

Ports:
- `Clock`  in  1: single clock, all state updates on rising edge.
- `Reset`  in  1: synchronous, active-high.
- `Data`  in  N: immediate operand for `mvi`.
- `w`  in  1: instruction request; sampled only in state T0.
- `F`  in  3: opcode.
- `Rx`  in  RW: destination / first operand register index.
- `Ry`  in  RW: source / second operand register index.
- `Done`  out  1: high during the final cycle of an instruction.
- `BusWires`  out  N: current internal bus value.
- `Carry`  out  1: carry/borrow flag.
- `Zero`  out  1: zero flag.

## Operation
- **Opcodes:**
  - 000 `mv`: Rx←Ry.
  - 001 `mvi`: Rx←Data.
  - 010 `add`: Rx←Rx+Ry.
  - 011 `sub`: Rx←Rx−Ry.
  - 100 `and`.
  - 101 `or`.
  - 110 `xor`.
  - 111 `cmp`: computes Rx−Ry, updates flags, no writeback.
- **Instruction register:** `{F,Rx,Ry}` is latched into a (3+2·RW)-bit instruction register on the edge ending T0 when `w`=1. Inputs are ignored afterwards until return to T0.
- **Step counter states:** T0 (idle), T1, T2, T3.
  - T0: `w`=1 → T1; else stay in T0.
  - `mv`/`mvi`: T1 drives the bus from Ry (`mv`) or `Data` (`mvi`) and loads Rx; `Done`=1; → T0.
  - ALU ops (010–110): T1 bus=Rx, A←bus; T2 bus=Ry, G←A op bus and flags update; T3 bus=G, Rx←bus, `Done`=1; → T0.
  - `cmp`: T1 and T2 as ALU ops; `Done`=1 in T2; → T0 (no T3, registers unchanged).
- **Bus:** multiplexed, not tri-state. Exactly one source per cycle; the bus is all-zero in T0.
- **Arithmetic:**
  - Modulo 2^N, unsigned.
  - `add`: Carry = carry-out of bit N−1.
  - `sub`/`cmp`: Carry = borrow, i.e. 1 iff A < Ry unsigned.
  - Logic ops clear Carry.
  - Zero = (result == 0).
  - Flags are updated only at the T2 edge of opcodes 010–111; `mv`/`mvi` leave flags unchanged.
- **Rx == Ry:** legal. `add` doubles, `sub` yields 0 with Zero=1 and Carry=0, `mv` is a no-op write.
- **Back-to-back issue:** `w` held high issues a new instruction on the first T0 after `Done`. There is always ≥1 T0 cycle between instructions.

## Timing
- Latency from the `w`-sampling edge:
  - `mv`/`mvi`: `Done` in the next cycle (2 cycles total incl. T0).
  - `cmp`: 3 cycles.
  - Other ALU ops: 4 cycles.
- Register write and `Done` are coincident: the destination register holds the new value on the edge that ends the `Done` cycle.
- `Done`, `BusWires` and register enables are combinational decodes of the state and instruction register. Flags, registers, A and G are registered.
- **Reset (synchronous):** when `Reset`=1 at a rising edge:
  - state→T0;
  - instruction register, all R registers, A, G, Carry and Zero → 0.
  - Therefore after reset: `Done`=0, `BusWires`=0, `Carry`=0, `Zero`=0.
  - Reset mid-instruction aborts it with no writeback; `Reset` has priority over `w`.
- `w` asserted in T1–T3 has no effect and is not queued.

## Test plan
- N=8, REGS=4: `mvi` R0 with Data=0x05 → `Done`=1 exactly 1 cycle after the issue edge; R0=0x05; flags unchanged (0,0).
- `mvi` R1=0xFF, `mvi` R2=0x01, `add` R1,R2 → `Done` in T3 (cycle 3 after issue); R1=0x00, Carry=1, Zero=1; bus shows 0xFF, 0x01, 0x00 in T1/T2/T3.
- R1=0x03, R2=0x05, `sub` R1,R2 → R1=0xFE, Carry=1, Zero=0. Then `cmp` R2,R2 → `Done` in T2, Zero=1, Carry=0, R2 still 0x05.
- `xor` R3,R3 with R3=0xA5 → R3=0x00, Zero=1, Carry=0. `w` pulsed in T2 → ignored; state returns to T0 with no extra instruction.
- `Reset` asserted in T2 of an `add` → next cycle state T0, `Done`=0, `BusWires`=0, all registers and flags 0, destination not written.
- Instance with N=16, REGS=8: `mvi` R7=0x8000, `mvi` R6=0x8000, `add` R7,R6 → R7=0x0000, Carry=1, Zero=1. `mv` R0,R7 → R0=0x0000.
